// File: rtl/axil_regbank_if.sv
// AXI-lite-style bus bundle between the button master and the register bank slave.
// The master drives addresses, data and the response readies; the slave answers.
interface axil_regbank_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) ();
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_W-1:0]     aw_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/4-1:0]   w_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_W-1:0]     ar_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_W-1:0]     r_data;
  logic [1:0]            r_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axil_regbank_slave.sv
// Parametrised register bank behind an AXI-lite-style slave with nibble strobes,
// OKAY/SLVERR responses, independent read/write channels and a debug read port.
module axil_regbank_slave #(
  parameter int                ADDR_W    = 3,
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 6,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  axil_regbank_if.slave     bus,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [7:0]        wr_count
);

  localparam int                STRB_W      = DATA_W / 4;
  localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic { WIDLE, WRESP } w_state_e;
  typedef enum logic { RIDLE, RDATA } r_state_e;

  w_state_e          w_state_q;
  r_state_e          r_state_q;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic              aw_ready_q, w_ready_q, ar_ready_q;
  logic              aw_held_q, w_held_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              b_valid_q, r_valid_q;
  logic [1:0]        b_resp_q, r_resp_q;
  logic [DATA_W-1:0] r_data_q;
  logic [7:0]        wr_count_q;

  logic              aw_hs, w_hs, ar_hs, wr_fire_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [STRB_W-1:0] wr_strb_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++)
      if (a == ADDR_W'(i)) v = regs_q[i];
    return v;
  endfunction

  assign aw_hs = bus.aw_valid & aw_ready_q;
  assign w_hs  = bus.w_valid & w_ready_q;
  assign ar_hs = bus.ar_valid & ar_ready_q;

  // The write uses whichever half was latched earlier and the other half live from the bus.
  assign wr_addr_d = aw_held_q ? aw_addr_q : bus.aw_addr;
  assign wr_data_d = w_held_q  ? w_data_q  : bus.w_data;
  assign wr_strb_d = w_held_q  ? w_strb_q  : bus.w_strb;
  assign wr_fire_d = (w_state_q == WIDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  always_comb begin
    // NOTE: default first so every path assigns dbg_data and no latch is inferred.
    dbg_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (dbg_sel == ADDR_W'(i)) dbg_data = regs_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is reset too, since reads after reset must return RESET_VAL.
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
      w_state_q  <= WIDLE;
      r_state_q  <= RIDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      ar_ready_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      wr_count_q <= '0;
    end else begin
      unique case (w_state_q)
        WIDLE: begin
          if (wr_fire_d) begin
            if (in_range(wr_addr_d)) begin
              for (int i = 0; i < DEPTH; i++)
                if (wr_addr_d == ADDR_W'(i))
                  for (int j = 0; j < STRB_W; j++)
                    if (wr_strb_d[j]) regs_q[i][4*j +: 4] <= wr_data_d[4*j +: 4];
              b_resp_q   <= RESP_OKAY;
              wr_count_q <= wr_count_q + 8'd1;
            end else begin
              b_resp_q   <= RESP_SLVERR;
            end
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b1;
            w_state_q  <= WRESP;
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              aw_addr_q <= bus.aw_addr;
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              w_data_q <= bus.w_data;
              w_strb_q <= bus.w_strb;
            end
            // Readies come back one edge after entering WIDLE, as they do after reset.
            aw_ready_q <= !(aw_held_q || aw_hs);
            w_ready_q  <= !(w_held_q || w_hs);
          end
        end
        WRESP: begin
          if (bus.b_ready) begin
            b_valid_q <= 1'b0;
            w_state_q <= WIDLE;
          end
        end
        default: w_state_q <= WIDLE;
      endcase

      unique case (r_state_q)
        RIDLE: begin
          ar_ready_q <= !ar_hs;
          if (ar_hs) begin
            if (in_range(bus.ar_addr)) begin
              r_data_q <= reg_at(bus.ar_addr);
              r_resp_q <= RESP_OKAY;
            end else begin
              r_data_q <= '0;
              r_resp_q <= RESP_SLVERR;
            end
            r_valid_q <= 1'b1;
            r_state_q <= RDATA;
          end
        end
        RDATA: begin
          if (bus.r_ready) begin
            r_valid_q <= 1'b0;
            r_state_q <= RIDLE;
          end
        end
        default: r_state_q <= RIDLE;
      endcase
    end
  end

  assign bus.aw_ready = aw_ready_q;
  assign bus.w_ready  = w_ready_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_resp   = b_resp_q;
  assign bus.ar_ready = ar_ready_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_axil_regbank_slave.sv
// Directed bench for axil_regbank_slave: write orders, strobes, SLVERR, stalls,
// read-before-write and reset in the middle of a write.
module tb_axil_regbank_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_sel;
  logic [7:0] dbg_data;
  logic [7:0] wr_count;
  int         checks = 0;
  int         errors = 0;

  axil_regbank_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  axil_regbank_slave #(.ADDR_W(3), .DATA_W(8), .DEPTH(6), .RESET_VAL(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.aw_valid = 1'b0; bus.aw_addr = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb = '0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0;
    bus.r_ready  = 1'b0;
  endtask

  task automatic wait_write_ready(input string name);
    for (int i = 0; i < 20 && !(bus.aw_ready && bus.w_ready); i++) tick();
    checks++;
    if (!(bus.aw_ready && bus.w_ready)) begin
      $display("FAIL %s_ready_timeout: aw_ready=%b w_ready=%b required 1 1", name, bus.aw_ready, bus.w_ready);
      errors++;
    end
  endtask

  task automatic wait_read_ready(input string name);
    for (int i = 0; i < 20 && !bus.ar_ready; i++) tick();
    checks++;
    if (!bus.ar_ready) begin
      $display("FAIL %s_ar_ready_timeout: ar_ready=%b required 1", name, bus.ar_ready);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    dbg_sel = 3'd0;
    tick(); tick();
    checks++;
    if ({bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid} !== 5'b0) begin
      $display("FAIL reset_flags: got %b required 00000",
               {bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid});
      errors++;
    end
    checks++;
    if ({bus.b_resp, bus.r_resp, bus.r_data, wr_count} !== 20'h0) begin
      $display("FAIL reset_values: b_resp=%b r_resp=%b r_data=%h wr_count=%0d required all 0",
               bus.b_resp, bus.r_resp, bus.r_data, wr_count);
      errors++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.aw_ready, bus.w_ready, bus.ar_ready} !== 3'b111) begin
      $display("FAIL reset_release_readies: got %b required 111", {bus.aw_ready, bus.w_ready, bus.ar_ready});
      errors++;
    end
    // Read of addr 3 right after reset.
    bus.ar_valid = 1'b1; bus.ar_addr = 3'd3;
    tick();
    bus.ar_valid = 1'b0;
    checks++;
    if ({bus.r_valid, bus.r_data, bus.r_resp} !== {1'b1, 8'h00, 2'b00}) begin
      $display("FAIL reset_read3: r_valid=%b r_data=%h r_resp=%b required 1 00 00", bus.r_valid, bus.r_data, bus.r_resp);
      errors++;
    end
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    wait_read_ready("reset_read3");
  endtask

  task automatic test_same_cycle();
    wait_write_ready("same_cycle");
    bus.aw_valid = 1'b1; bus.aw_addr = 3'd2;
    bus.w_valid  = 1'b1; bus.w_data  = 8'hA5; bus.w_strb = 2'b11;
    bus.b_ready  = 1'b1;
    dbg_sel = 3'd2;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    checks++;
    if ({bus.b_valid, bus.b_resp, bus.aw_ready, bus.w_ready} !== 5'b1_00_00) begin
      $display("FAIL same_cycle_bresp: b_valid=%b b_resp=%b aw_ready=%b w_ready=%b required 1 00 0 0",
               bus.b_valid, bus.b_resp, bus.aw_ready, bus.w_ready);
      errors++;
    end
    checks++;
    if ({dbg_data, wr_count} !== {8'hA5, 8'd1}) begin
      $display("FAIL same_cycle_data: dbg=%h wr_count=%0d required a5 1", dbg_data, wr_count);
      errors++;
    end
    tick();
    bus.b_ready = 1'b0;
    checks++;
    if ({bus.b_valid, bus.aw_ready} !== 2'b00) begin
      $display("FAIL same_cycle_bdone: b_valid=%b aw_ready=%b required 0 0", bus.b_valid, bus.aw_ready);
      errors++;
    end
    tick();
    checks++;
    if ({bus.aw_ready, bus.w_ready} !== 2'b11) begin
      $display("FAIL same_cycle_readies_back: got %b required 11", {bus.aw_ready, bus.w_ready});
      errors++;
    end
  endtask

  task automatic test_w_first();
    wait_write_ready("w_first");
    bus.w_valid = 1'b1; bus.w_data = 8'h3C; bus.w_strb = 2'b01;
    dbg_sel = 3'd2;
    tick();
    bus.w_valid = 1'b0; bus.w_data = 8'hFF;
    checks++;
    if ({bus.w_ready, bus.aw_ready, bus.b_valid} !== 3'b010) begin
      $display("FAIL w_first_latched: w_ready=%b aw_ready=%b b_valid=%b required 0 1 0",
               bus.w_ready, bus.aw_ready, bus.b_valid);
      errors++;
    end
    tick(); tick();
    checks++;
    if ({bus.b_valid, dbg_data} !== {1'b0, 8'hA5}) begin
      $display("FAIL w_first_waiting: b_valid=%b dbg=%h required 0 a5", bus.b_valid, dbg_data);
      errors++;
    end
    bus.aw_valid = 1'b1; bus.aw_addr = 3'd2;
    tick();
    bus.aw_valid = 1'b0;
    checks++;
    if ({bus.b_valid, bus.b_resp, dbg_data, wr_count} !== {1'b1, 2'b00, 8'hAC, 8'd2}) begin
      $display("FAIL w_first_done: b_valid=%b b_resp=%b dbg=%h wr_count=%0d required 1 00 ac 2",
               bus.b_valid, bus.b_resp, dbg_data, wr_count);
      errors++;
    end
    // Response held while b_ready stays low.
    tick();
    checks++;
    if ({bus.b_valid, bus.b_resp} !== 3'b1_00) begin
      $display("FAIL w_first_bhold: b_valid=%b b_resp=%b required 1 00", bus.b_valid, bus.b_resp);
      errors++;
    end
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
  endtask

  task automatic test_slverr();
    logic [7:0] exp_regs [6];
    exp_regs = '{8'h00, 8'h00, 8'hAC, 8'h00, 8'h00, 8'h00};
    wait_write_ready("slverr");
    bus.aw_valid = 1'b1; bus.aw_addr = 3'd7;
    bus.w_valid  = 1'b1; bus.w_data  = 8'hFF; bus.w_strb = 2'b11;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    checks++;
    if ({bus.b_valid, bus.b_resp, wr_count} !== {1'b1, 2'b10, 8'd2}) begin
      $display("FAIL slverr_write: b_valid=%b b_resp=%b wr_count=%0d required 1 10 2", bus.b_valid, bus.b_resp, wr_count);
      errors++;
    end
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      checks++;
      if (dbg_data !== ((i < 6) ? exp_regs[i] : 8'h00)) begin
        $display("FAIL slverr_regs[%0d]: got %h required %h", i, dbg_data, (i < 6) ? exp_regs[i] : 8'h00);
        errors++;
      end
    end
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    wait_read_ready("slverr_read6");
    bus.ar_valid = 1'b1; bus.ar_addr = 3'd6;
    tick();
    bus.ar_valid = 1'b0;
    checks++;
    if ({bus.r_valid, bus.r_data, bus.r_resp} !== {1'b1, 8'h00, 2'b10}) begin
      $display("FAIL slverr_read6: r_valid=%b r_data=%h r_resp=%b required 1 00 10", bus.r_valid, bus.r_data, bus.r_resp);
      errors++;
    end
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
  endtask

  task automatic test_read_stall();
    wait_read_ready("stall");
    wait_write_ready("stall");
    bus.ar_valid = 1'b1; bus.ar_addr = 3'd2;
    tick();
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b1; bus.aw_addr = 3'd1;
    bus.w_valid  = 1'b1; bus.w_data  = 8'h11; bus.w_strb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.r_valid, bus.r_data, bus.r_resp, bus.ar_ready} !== {1'b1, 8'hAC, 2'b00, 1'b0}) begin
        $display("FAIL stall_hold[%0d]: r_valid=%b r_data=%h r_resp=%b ar_ready=%b required 1 ac 00 0",
                 i, bus.r_valid, bus.r_data, bus.r_resp, bus.ar_ready);
        errors++;
      end
      tick();
      if (i == 0) begin
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        checks++;
        if ({bus.b_valid, bus.b_resp} !== 3'b1_00) begin
          $display("FAIL stall_write_resp: b_valid=%b b_resp=%b required 1 00", bus.b_valid, bus.b_resp);
          errors++;
        end
        bus.b_ready = 1'b1;
      end else begin
        bus.b_ready = 1'b0;
      end
    end
    dbg_sel = 3'd1;
    #1;
    checks++;
    if ({bus.b_valid, dbg_data, wr_count} !== {1'b0, 8'h11, 8'd3}) begin
      $display("FAIL stall_write_done: b_valid=%b dbg=%h wr_count=%0d required 0 11 3", bus.b_valid, dbg_data, wr_count);
      errors++;
    end
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    checks++;
    if ({bus.r_valid, bus.ar_ready} !== 2'b00) begin
      $display("FAIL stall_release: r_valid=%b ar_ready=%b required 0 0", bus.r_valid, bus.ar_ready);
      errors++;
    end
  endtask

  task automatic test_read_before_write();
    wait_read_ready("rbw");
    wait_write_ready("rbw");
    bus.ar_valid = 1'b1; bus.ar_addr = 3'd1;
    bus.aw_valid = 1'b1; bus.aw_addr = 3'd1;
    bus.w_valid  = 1'b1; bus.w_data  = 8'h22; bus.w_strb = 2'b10;
    bus.b_ready  = 1'b1; bus.r_ready = 1'b1;
    dbg_sel = 3'd1;
    tick();
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    checks++;
    if ({bus.r_valid, bus.r_data, bus.b_valid, dbg_data, wr_count} !== {1'b1, 8'h11, 1'b1, 8'h21, 8'd4}) begin
      $display("FAIL rbw: r_valid=%b r_data=%h b_valid=%b dbg=%h wr_count=%0d required 1 11 1 21 4",
               bus.r_valid, bus.r_data, bus.b_valid, dbg_data, wr_count);
      errors++;
    end
    tick();
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    // Zero-strobe write still counts as an OKAY write.
    wait_write_ready("zero_strb");
    bus.aw_valid = 1'b1; bus.aw_addr = 3'd1;
    bus.w_valid  = 1'b1; bus.w_data  = 8'hEE; bus.w_strb = 2'b00;
    bus.b_ready  = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    checks++;
    if ({bus.b_resp, dbg_data, wr_count} !== {2'b00, 8'h21, 8'd5}) begin
      $display("FAIL zero_strb: b_resp=%b dbg=%h wr_count=%0d required 00 21 5", bus.b_resp, dbg_data, wr_count);
      errors++;
    end
    tick();
    bus.b_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    wait_write_ready("rst_mid");
    bus.aw_valid = 1'b1; bus.aw_addr = 3'd0;
    tick();
    bus.aw_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.aw_ready, bus.w_ready, bus.b_valid, wr_count} !== {3'b000, 8'd0}) begin
      $display("FAIL rst_mid_async: aw_ready=%b w_ready=%b b_valid=%b wr_count=%0d required 0 0 0 0",
               bus.aw_ready, bus.w_ready, bus.b_valid, wr_count);
      errors++;
    end
    for (int i = 0; i < 6; i++) begin
      dbg_sel = 3'(i);
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin
        $display("FAIL rst_mid_reg[%0d]: got %h required 00", i, dbg_data);
        errors++;
      end
    end
    tick();
    rst = 1'b0;
    tick();
    // W alone must not complete the discarded AW.
    bus.w_valid = 1'b1; bus.w_data = 8'h5A; bus.w_strb = 2'b11;
    bus.b_ready = 1'b1;
    dbg_sel = 3'd0;
    tick();
    bus.w_valid = 1'b0;
    checks++;
    if ({bus.b_valid, dbg_data, wr_count} !== {1'b0, 8'h00, 8'd0}) begin
      $display("FAIL rst_mid_no_ghost: b_valid=%b dbg=%h wr_count=%0d required 0 00 0", bus.b_valid, dbg_data, wr_count);
      errors++;
    end
    bus.aw_valid = 1'b1; bus.aw_addr = 3'd0;
    tick();
    bus.aw_valid = 1'b0;
    checks++;
    if ({bus.b_valid, bus.b_resp, dbg_data, wr_count} !== {1'b1, 2'b00, 8'h5A, 8'd1}) begin
      $display("FAIL rst_mid_rewrite: b_valid=%b b_resp=%b dbg=%h wr_count=%0d required 1 00 5a 1",
               bus.b_valid, bus.b_resp, dbg_data, wr_count);
      errors++;
    end
    tick();
    bus.b_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_slverr();
    test_read_stall();
    test_read_before_write();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
